// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the 16-bit CPU to RAM bridge.
package mem_bridge_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [2:0] {
    IDLE,
    ACC1,
    WAIT1,
    ACC2,
    WAIT2,
    DONE
  } state_t;

  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_BOTH = 2'b11;

  // Widen a read byte to 16 bits, replicating bit 7 when sign extension is requested.
  function automatic logic [DATA_W-1:0] byte_ext(input logic [7:0] b, input logic sx);
    return {(sx ? {8{b[7]}} : 8'h00), b};
  endfunction

endpackage

// File: rtl/mem_bridge.sv
// Bridge from a byte-addressed big-endian CPU port to a 16-bit word RAM.
// Unaligned word accesses are split into two RAM accesses across a word boundary.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic                cpu_be,
  input  logic                cpu_sx,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_ready,
  output logic                cpu_done,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-2:0]   ram_addr,
  output logic [1:0]          ram_be,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int unsigned      WA_W      = ADDR_W - 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic               r_be;
  logic               r_sx;
  logic               r_odd;
  logic               r_split;
  logic               r_ready;
  logic               r_done;
  logic               r_ram_en;
  logic               r_ram_we;
  logic [WA_W-1:0]    r_ram_addr;
  logic [WA_W-1:0]    r_next_waddr;
  logic [1:0]         r_ram_be;
  logic [DATA_W-1:0]  r_ram_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic [7:0]         r_byte2;
  logic [7:0]         r_lo_byte;

  logic [WA_W-1:0]    w_waddr;
  logic               w_split;
  logic [1:0]         w_be;
  logic [DATA_W-1:0]  w_wdata;
  logic [DATA_W-1:0]  w_rd_single;

  assign w_waddr = cpu_addr[ADDR_W-1:1];
  assign w_split = ~cpu_be & cpu_addr[0];

  // Lane enables and steered write data for the first (or only) RAM access.
  always_comb begin
    w_be    = LANE_BOTH;
    w_wdata = cpu_wdata;
    if (cpu_be) begin
      if (cpu_addr[0]) begin
        w_be    = LANE_LO;
        w_wdata = {8'h00, cpu_wdata[7:0]};
      end else begin
        w_be    = LANE_HI;
        w_wdata = {cpu_wdata[7:0], 8'h00};
      end
    end else if (cpu_addr[0]) begin
      // Unaligned word: byte A (high half of the CPU data) goes to the low lane of word W.
      w_be    = LANE_LO;
      w_wdata = {8'h00, cpu_wdata[15:8]};
    end
    if (!cpu_we) begin
      w_wdata = '0;
    end
  end

  // Read result for a single-access read: full word or extended byte from the addressed lane.
  always_comb begin
    w_rd_single = ram_rdata;
    if (r_be) begin
      w_rd_single = byte_ext(r_odd ? ram_rdata[7:0] : ram_rdata[15:8], r_sx);
    end
  end

  // Transaction sequencer with registered CPU and RAM side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_be         <= 1'b0;
      r_sx         <= 1'b0;
      r_odd        <= 1'b0;
      r_split      <= 1'b0;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_next_waddr <= '0;
      r_ram_be     <= '0;
      r_ram_wdata  <= '0;
      r_rdata      <= '0;
      r_byte2      <= '0;
      r_lo_byte    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            r_we         <= cpu_we;
            r_be         <= cpu_be;
            r_sx         <= cpu_sx;
            r_odd        <= cpu_addr[0];
            r_split      <= w_split;
            r_byte2      <= cpu_wdata[7:0];
            r_next_waddr <= w_waddr + WA_W'(1);
            r_ready      <= 1'b0;
            r_ram_en     <= 1'b1;
            r_ram_we     <= cpu_we;
            r_ram_addr   <= w_waddr;
            r_ram_be     <= w_be;
            r_ram_wdata  <= w_wdata;
            r_state      <= ACC1;
          end
        end
        ACC1: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          if (r_we) begin
            if (r_split) begin
              // Second write half follows immediately: byte A+1 into the high lane of W+1.
              r_ram_en    <= 1'b1;
              r_ram_we    <= 1'b1;
              r_ram_addr  <= r_next_waddr;
              r_ram_be    <= LANE_HI;
              r_ram_wdata <= {r_byte2, 8'h00};
              r_state     <= ACC2;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end else begin
            r_cnt   <= WAIT_LOAD;
            r_state <= WAIT1;
          end
        end
        WAIT1: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_split) begin
            r_lo_byte   <= ram_rdata[7:0];
            r_ram_en    <= 1'b1;
            r_ram_addr  <= r_next_waddr;
            r_ram_be    <= LANE_HI;
            r_ram_wdata <= '0;
            r_state     <= ACC2;
          end else begin
            r_rdata <= w_rd_single;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        ACC2: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          if (r_we) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= WAIT_LOAD;
            r_state <= WAIT2;
          end
        end
        WAIT2: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rdata <= {r_lo_byte, ram_rdata[15:8]};
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ready = r_ready;
  assign cpu_done  = r_done;
  assign cpu_rdata = r_rdata;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_be    = r_ram_be;
  assign ram_wdata = r_ram_wdata;

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter ADDR_W, default 16, CPU byte-address width; RAM word address is ADDR_W-1 bits.
REQ-002 Parameter RD_LAT, default 1, RAM read latency in cycles, legal range 1..4.
REQ-003 One clock; reset is synchronous and active-high. Ports are named clk and reset.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 cpu_req  in  1  access request, held until accepted.
REQ-007 cpu_we  in  1  1 = write, 0 = read.
REQ-008 cpu_be  in  1  1 = byte access, 0 = 16-bit word access.
REQ-009 cpu_sx  in  1  byte reads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 cpu_addr  in  ADDR_W  byte address; big-endian (even byte = bits 15:8 of the RAM word).
REQ-011 cpu_wdata  in  16  write data; byte writes use bits 7:0.
REQ-012 cpu_ready  out  1  high only in IDLE; request accepted on cycle where cpu_req and cpu_ready are both high.
REQ-013 cpu_done  out  1  one-cycle completion pulse for reads and writes.
REQ-014 cpu_rdata  out  16  read result, valid while cpu_done is high, held until next completion.
REQ-015 ram_en, ram_we  out  1 each  registered RAM strobe and write enable.
REQ-016 ram_addr  out  ADDR_W-1  registered word address.
REQ-017 ram_be  out  2  registered lane enables (bit1 = high byte).
REQ-018 ram_wdata  out  16  registered write data; disabled lanes drive 0.
REQ-019 ram_rdata  in  16  valid RD_LAT cycles after the ram_en cycle.

Function
REQ-020 Request fields are latched at acceptance; cpu_* inputs are ignored outside IDLE.
REQ-021 States: IDLE, ACC1, WAIT1, ACC2, WAIT2, DONE; ram_en is high only in ACC1/ACC2.
REQ-022 Accepted at edge ending cycle T: ACC1 in T+1 with ram_addr = addr[ADDR_W-1:1].
REQ-023 Byte access: single access; ram_be = 10 for even addr, 01 for odd; write data placed in the selected lane.
REQ-024 Aligned word (addr[0]=0): single access, ram_be = 11, ram_wdata = cpu_wdata.
REQ-025 Unaligned word (addr[0]=1): two accesses; first to word W with ram_be=01 carrying byte A; second to W+1 mod 2^(ADDR_W-1) with ram_be=10 carrying byte A+1.
REQ-026 Unaligned read result = {low byte of word W, high byte of word W+1}.
REQ-027 WAIT states count RD_LAT-1 cycles (0 for RD_LAT=1) via a down-counter; ram_rdata captured at the edge ending cycle ACCn+RD_LAT.
REQ-028 Writes skip WAIT states; the second write access follows ACC1 directly.
REQ-029 Latency from acceptance edge to cpu_done cycle (RD_LAT=L): single write 2, split write 3, single read L+2, split read 2L+3.
REQ-030 Byte reads: result in bits 7:0; bits 15:8 = 0x00, or replicate bit 7 when cpu_sx=1.
REQ-031 DONE lasts one cycle, then IDLE; cpu_ready low in DONE (no back-to-back acceptance).
REQ-032 Word-address wrap at top of memory is silent modulo arithmetic; no error output.

Reset
REQ-033 Reset forces IDLE, latency counter 0, cpu_done=0, cpu_rdata=0, ram_en=0, ram_we=0, ram_be=00, ram_addr=0, ram_wdata=0 on the next edge.
REQ-034 Reset mid-transaction abandons it: no cpu_done, and any split second half is not issued; cpu_ready=1 in the first cycle after reset deasserts.

Structure
REQ-035 Package mem_bridge_pkg holds the state enum and lane constants (LANE_HI=2'b10, LANE_LO=2'b01, LANE_BOTH=2'b11).
REQ-036 Single module; lane steering and read assembly are inline. No sub-module.

Verification (ADDR_W=16, RD_LAT=1 unless noted)
REQ-037 Byte write 0xAB to addr 0x0011 -> one ram_en cycle, ram_addr=0x0008, ram_be=01, ram_wdata=0x00AB, cpu_done 2 cycles after accept.
REQ-038 RAM word 0x0008=0x12F4; byte read addr 0x0011, cpu_sx=1 -> cpu_rdata=0xFFF4; addr 0x0010, cpu_sx=0 -> 0x0012.
REQ-039 Word write 0xBEEF to addr 0x0021 -> word 0x0010 be=01 data 0x00BE, then word 0x0011 be=10 data 0xEF00, cpu_done 3 cycles after accept.
REQ-040 Word read addr 0xFFFF with word 0x7FFF=0x1122, word 0x0000=0x3344 -> second ram_addr=0x0000, cpu_rdata=0x2233, cpu_done 5 cycles after accept.
REQ-041 RD_LAT=3, aligned read addr 0x0100 -> cpu_done exactly 5 cycles after accept; cpu_ready low throughout.
REQ-042 reset asserted the cycle after ACC1 of a split write -> no second ram_en, no cpu_done, all outputs at reset values.
